// File: rtl/fft_pkg.sv
// Shared types for the 8-point FFT datapath: frame geometry and complex word layout.
// No logic; types and constants only.
// No flow control; consumers define their own handshakes.
package fft_pkg;

    localparam int FFT_NPT = 8;
    localparam int FFT_CW  = 64;

    // One complex coefficient, real part in the upper half
    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    // A whole 8-point result frame, coefficient k at index k
    typedef cplx_t [7:0] frame_t;

endpackage

// File: rtl/fft8_bank.sv
// One ping-pong half: holds a full 8-coefficient frame and muxes out one word by index.
// Write lands at the clock edge; read is a pure register mux (zero latency).
// No flow control; the owner decides when to write and which word to present.
import fft_pkg::*;

module fft8_bank (
    input  logic       clk,
    input  logic       we,
    input  frame_t     wdata,
    input  logic [2:0] rd_idx,
    output cplx_t      rdata
);

    frame_t mem;

    // Whole-frame capture; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem <= wdata;
        end
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/fft8_out_ser.sv
// Serializes 8-point FFT result frames into a valid/ready word stream via a ping-pong buffer.
// First word valid the cycle after the capture strobe; 1 word/cycle sustained with ready high.
// Holds the word while out_ready is low; raises stall when both banks are full, drops and flags ovf otherwise.
import fft_pkg::*;

module fft8_out_ser #(
    parameter int DW  = FFT_CW,
    parameter int NPT = FFT_NPT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [DW-1:0] x3,
    input  logic [DW-1:0] x4,
    input  logic [DW-1:0] x5,
    input  logic [DW-1:0] x6,
    input  logic [DW-1:0] x7,
    output logic          stall,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_index,
    output logic          out_last,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam logic [2:0] LAST_IDX = 3'(NPT - 1);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] rd_idx;

    frame_t     wframe;
    cplx_t      rdata0;
    cplx_t      rdata1;
    cplx_t      rsel;

    logic       cap;
    logic       drop;
    logic       hs;
    logic       done;

    assign wframe = {x7, x6, x5, x4, x3, x2, x1, x0};

    // Stall is a pure decode of the occupancy flags, never of out_ready
    assign stall = &full;
    assign cap   = in_valid && !stall;
    assign drop  = in_valid && stall;

    assign out_valid = full[rd_bank];
    assign hs        = out_valid && out_ready;
    assign done      = hs && (rd_idx == LAST_IDX);

    fft8_bank u_bank0 (
        .clk    (clk),
        .we     (cap && !wr_bank),
        .wdata  (wframe),
        .rd_idx (rd_idx),
        .rdata  (rdata0)
    );

    fft8_bank u_bank1 (
        .clk    (clk),
        .we     (cap && wr_bank),
        .wdata  (wframe),
        .rd_idx (rd_idx),
        .rdata  (rdata1)
    );

    assign rsel      = rd_bank ? rdata1 : rdata0;
    // Empty banks present zero so stale or never-written contents stay invisible
    assign out_data  = out_valid ? rsel : '0;
    assign out_index = rd_idx;
    assign out_last  = (rd_idx == LAST_IDX);

    // Next occupancy: a capture and a final-word drain never touch the same bank
    always_comb begin
        full_nxt = full;
        if (done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (cap) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Bank pointers, read index and sticky overflow; reset discards any buffered frames
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_idx  <= 3'd0;
            ovf     <= 1'b0;
        end else begin
            full <= full_nxt;
            if (cap) begin
                wr_bank <= ~wr_bank;
            end
            if (hs) begin
                rd_idx <= done ? 3'd0 : rd_idx + 3'd1;
            end
            if (done) begin
                rd_bank <= ~rd_bank;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fft8_out_ser.md
# fft8_out_ser

Output serializer for the 8-point FFT core. It captures one 8-point result frame (eight 64-bit complex coefficients, `{re[31:0], im[31:0]}`) on a single-cycle strobe into a ping-pong double buffer and streams the words out one per handshake, in coefficient order 0..7. It drives the core's `stall` input so the core's result registers freeze while both banks are occupied.

## Interface
- `DW`, 64: coefficient word width, `{re, im}`, DW/2 bits each.
- `NPT`, 8: points per frame. Fixed at 8; any other value is unsupported.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: frame strobe; `x0..x7` are valid this cycle.
- `x0`..`x7`  in  DW each: FFT coefficients k=0..7 from the core.
- `stall`  out  1: to the core's `stall`; high when both banks are full.
- `out_data`  out  DW: current coefficient word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: sink accepts the word this cycle.
- `out_index`  out  3: coefficient number k of `out_data`.
- `out_last`  out  1: high with k=7.
- `ovf`  out  1: sticky; a frame was dropped.
- `ovf_clr`  in  1: clears `ovf`.

## Operation
- State:
  - two banks of 8×DW registers, `full[1:0]`, `wr_bank`, `rd_bank`, and a 3-bit `rd_idx`.
  - occupancy `cnt` = `full[0]+full[1]`, range 0..2.
- Capture:
  - `in_valid && !stall`: all eight inputs are written to bank `wr_bank`. `full[wr_bank]` sets and `wr_bank` toggles.
  - `in_valid && stall`: the frame is dropped and `ovf` sets. This holds even if a drain completes in the same cycle.
- Drain:
  - `out_valid` = `full[rd_bank]`.
  - `out_data` = `bank[rd_bank][rd_idx]`, a mux of registers only. There is no combinational path from `x*` or `in_valid` to any output.
  - A handshake is `out_valid && out_ready`. It increments `rd_idx`.
  - A handshake at `rd_idx==7` clears `full[rd_bank]`, toggles `rd_bank`, and wraps `rd_idx` to 0.
- Stability: while `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold.
- `stall` = (`cnt==2`), decoded from registered state only. It does not depend combinationally on `out_ready`.
- Simultaneous capture and final-word handshake with `cnt==1`:
  - the capture goes to the empty bank and the drain frees the other;
  - `cnt` stays 1 and the new frame streams immediately.
- Simultaneous `ovf_clr` and a drop: set wins.
- Arithmetic: none on the data. Words pass through bit-exact.
- Reset, applied at any time including mid-frame:
  - `full`=0, `wr_bank`=`rd_bank`=0, `rd_idx`=0, so any partial frame is discarded;
  - `out_valid`=0, `out_index`=0, `out_last`=0, `stall`=0, `ovf`=0;
  - `out_data` is forced to 0 while the banks are empty. Bank contents need no reset.

## Timing
- Capture to first word: strobe at edge N gives `out_valid`=1 after edge N, when the bank being read is free.
- Throughput: 1 word/cycle with `out_ready` held high. A steady frame every 8 cycles never asserts `stall`.
- `stall` rises the cycle after the capture that fills the second bank. It falls the cycle after the handshake of k=7 of the older frame.
- Because the core's result registers freeze under `stall`, the controller must not pulse `in_valid` while `stall` is high. A pulse in that window only causes a drop and sets `ovf`.

## Structure
- Shared package `fft_pkg`:
  - `FFT_NPT`=8 and `FFT_CW`=64;
  - typedef `cplx_t` = packed struct `{logic signed [31:0] re, im}`;
  - typedef `frame_t` = `cplx_t [7:0]`.
- One sub-module, `fft8_bank`: an 8-word register bank with a whole-frame write port and a 3-bit-indexed read mux. It is instantiated twice.
- Top level holds the full flags, bank pointers, `rd_idx`, and the `stall`/`ovf` logic.

## Test plan
- Single frame, `x_k = {k+1, -(k+1)}`, `out_ready`=1: words 1..8 appear with `out_index` 0..7, `out_last` only at 7, `out_valid` low afterwards.
- Backpressure: `out_ready` toggles 1,0,0,1 repeatedly. Each word holds while not ready, no word is duplicated or skipped, and 8 handshakes complete the frame.
- Two frames back-to-back with `out_ready`=0: `stall`=1 from the 3rd cycle. A third strobe sets `ovf`. Frame A then frame B drain intact, `stall` drops after A's k=7, and `ovf_clr` clears `ovf`.
- Strobe in the same cycle as the k=7 handshake with `cnt==1`: there is no gap in `out_valid`, and the new frame's k=0 appears next cycle.
- Reset asserted at `out_index`=4 with 2 frames buffered: the next cycle `out_valid`=0, `stall`=0, `ovf`=0. A fresh frame then streams from k=0.
- Pass-through extremes: `re=32'h8000_0000`, `im=32'h7FFF_FFFF` in all lanes come out bit-exact.
